fetch_queue: RTL and testbench

Parametrised successor to the single-register fetch stage. Decouples instruction-memory latency from the pipeline with a DEPTH-entry prefetch queue and a valid/ready request plus in-order response memory interface. Supports branch redirect with flush and discard of in-flight responses. Sits between the instruction memory and the IF/ID pipeline register, and drives that register directly.

---
 rtl/fetch_queue.sv | 164 ++++++++++++++++
 tb/tb_fetch_queue.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Prefetching instruction fetch stage: DEPTH-entry queue fed by a valid/ready, in-order
// instruction memory, with branch flush. Optional perf counters under FETCH_PERF_CNT_EN.
module fetch_queue #(
  parameter int unsigned           ADDR_W   = 32,
  parameter int unsigned           DATA_W   = 32,
  parameter int unsigned           DEPTH    = 4,
  parameter int unsigned           PC_STEP  = 1,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              stall_c,
  input  logic              branch_c,
  input  logic [ADDR_W-1:0] branch_pc,
  output logic              im_req_valid,
  input  logic              im_req_ready,
  output logic [ADDR_W-1:0] im_req_addr,
  input  logic              im_rsp_valid,
  input  logic [DATA_W-1:0] im_rsp_data,
  output logic              im_write_enable,
  output logic              IF_ID_valid,
  output logic [DATA_W-1:0] IF_ID_IR,
  output logic [ADDR_W-1:0] IF_ID_nextPC
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_bubble_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  localparam int unsigned       PTR_W   = $clog2(DEPTH);
  localparam int unsigned       CNT_W   = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);
  localparam logic [CNT_W:0]    DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, fill_pc_q, fill_pc_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d, inflight_q, inflight_d, drop_q, drop_d;
  logic              if_valid_q, if_valid_d;
  logic [DATA_W-1:0] if_ir_q, if_ir_d;
  logic [ADDR_W-1:0] if_npc_q, if_npc_d;

  logic [CNT_W:0]    credit_used;
  logic              accept, push, pop, queue_empty;

  assign credit_used     = {1'b0, count_q} + {1'b0, inflight_q};
  assign queue_empty     = (count_q == '0);
  assign im_req_valid    = !branch_c && (credit_used < DEPTH_C);
  assign im_req_addr     = fetch_pc_q;
  assign im_write_enable = 1'b0;
  assign accept          = im_req_valid && im_req_ready;
  // A response is kept only when it is not owed to a pre-branch request and no branch is flushing now.
  assign push            = im_rsp_valid && !branch_c && (drop_q == '0);
  assign pop             = !branch_c && !stall_c && !queue_empty;

  assign IF_ID_valid  = if_valid_q;
  assign IF_ID_IR     = if_ir_q;
  assign IF_ID_nextPC = if_npc_q;

  always_comb begin
    // NOTE: every next-state value is defaulted first so no path leaves one unassigned (no latches).
    fetch_pc_d = fetch_pc_q;
    fill_pc_d  = fill_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(im_rsp_valid);
    drop_d     = drop_q;
    if_valid_d = if_valid_q;
    if_ir_d    = if_ir_q;
    if_npc_d   = if_npc_q;

    if (accept) fetch_pc_d = fetch_pc_q + STEP;
    if (im_rsp_valid && (drop_q != '0)) drop_d = drop_q - 1'b1;
    if (push) begin
      fill_pc_d = fill_pc_q + STEP;
      wr_ptr_d  = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    if (branch_c) begin
      // Every request still outstanding after this cycle belongs to the old path.
      fetch_pc_d = branch_pc;
      fill_pc_d  = branch_pc;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      drop_d     = inflight_q - CNT_W'(im_rsp_valid);
      if_valid_d = 1'b0;
      if_ir_d    = '0;
    end else if (!stall_c) begin
      if (!queue_empty) begin
        if_valid_d = 1'b1;
        if_ir_d    = data_mem[rd_ptr_q];
        if_npc_d   = pc_mem[rd_ptr_q] + STEP;
      end else begin
        if_valid_d = 1'b0;
        if_ir_d    = '0;
      end
    end
  end

  // NOTE: state uses non-blocking assignments and a synchronous reset sampled on clock.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fetch_pc_q <= RESET_PC;
      fill_pc_q  <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      if_valid_q <= 1'b0;
      if_ir_q    <= '0;
      if_npc_q   <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      fill_pc_q  <= fill_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      if_valid_q <= if_valid_d;
      if_ir_q    <= if_ir_d;
      if_npc_q   <= if_npc_d;
    end
  end

  // NOTE: queue storage is not reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= fill_pc_q;
      data_mem[wr_ptr_q] <= im_rsp_data;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] bubble_cnt_q, flush_cnt_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (!branch_c && !stall_c && queue_empty && (bubble_cnt_q != '1))
        bubble_cnt_q <= bubble_cnt_q + 1'b1;
      if (branch_c && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign perf_bubble_cnt = bubble_cnt_q;
  assign perf_flush_cnt  = flush_cnt_q;
`endif

  rsp_needs_inflight: assert property (@(posedge clock) disable iff (!reset_n)
    !(im_rsp_valid && (inflight_q == '0)));

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios then random traffic, compared each
// cycle against a queue-based model of outstanding requests and prefetched instructions.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;

  typedef struct { logic [31:0] addr; bit drop; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall_c = 1'b0, branch_c = 1'b0, im_req_ready = 1'b0, im_rsp_valid = 1'b0;
  logic [31:0] branch_pc = '0, im_rsp_data = '0;
  logic        im_req_valid, im_write_enable, IF_ID_valid;
  logic [31:0] im_req_addr, IF_ID_IR, IF_ID_nextPC;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_bubble_cnt, perf_flush_cnt;
`endif

  fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .PC_STEP(1), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset_n(reset_n), .stall_c(stall_c), .branch_c(branch_c),
    .branch_pc(branch_pc), .im_req_valid(im_req_valid), .im_req_ready(im_req_ready),
    .im_req_addr(im_req_addr), .im_rsp_valid(im_rsp_valid), .im_rsp_data(im_rsp_data),
    .im_write_enable(im_write_enable), .IF_ID_valid(IF_ID_valid), .IF_ID_IR(IF_ID_IR),
    .IF_ID_nextPC(IF_ID_nextPC)
`ifdef FETCH_PERF_CNT_EN
    , .perf_bubble_cnt(perf_bubble_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0, n_errors = 0;

  // Controls for the next cycle
  bit          c_rst_n = 1'b0, c_stall = 1'b0, c_branch = 1'b0, c_ready = 1'b0;
  logic [31:0] c_bpc = '0;
  int          rsp_mode = 0;  // 0 withhold, 1 respond when possible, 2 random

  // Memory side of the bench
  logic [31:0] mem_q[$];
  int          req_cnt = 0;
  logic [31:0] last_acc_addr = '1;
  logic [31:0] ir_seq[$];
  bit          armed = 1'b0;

  // Reference model
  logic [31:0] m_fetch_pc = '0;
  req_t        out_q[$];
  ent_t        fq[$];
  logic        m_valid = 1'b0;
  logic [31:0] m_ir = '0, m_npc = '0;

  function automatic logic [31:0] word(logic [31:0] a);
    return a + 32'hA0;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_update(bit acc, bit rsp);
    req_t e;
    ent_t f;
    bit   got;
    if (!c_rst_n) begin
      m_fetch_pc = '0; out_q.delete(); fq.delete();
      m_valid = 1'b0; m_ir = '0; m_npc = '0;
      return;
    end
    got = 1'b0;
    if (rsp && out_q.size() > 0) begin e = out_q.pop_front(); got = 1'b1; end
    if (c_branch) begin
      fq.delete();
      m_valid = 1'b0; m_ir = '0;
      m_fetch_pc = c_bpc;
      foreach (out_q[i]) out_q[i].drop = 1'b1;
    end else if (!c_stall) begin
      if (fq.size() > 0) begin
        f = fq.pop_front();
        m_valid = 1'b1; m_ir = f.data; m_npc = f.pc + 32'd1;
      end else begin
        m_valid = 1'b0; m_ir = '0;
      end
    end
    if (got && !e.drop && !c_branch) fq.push_back('{pc: e.addr, data: word(e.addr)});
    if (acc) begin
      out_q.push_back('{addr: m_fetch_pc, drop: 1'b0});
      m_fetch_pc = m_fetch_pc + 32'd1;
    end
  endtask

  // One clock cycle: drive, check request side, advance model, clock, check IF/ID.
  task automatic step();
    bit rsp, m_req, acc;
    reset_n = c_rst_n; stall_c = c_stall; branch_c = c_branch;
    branch_pc = c_bpc; im_req_ready = c_ready;
    rsp = 1'b0;
    if (mem_q.size() > 0) begin
      if (rsp_mode == 1) rsp = 1'b1;
      else if (rsp_mode == 2) rsp = 1'($urandom_range(0, 1));
    end
    im_rsp_valid = rsp;
    im_rsp_data  = rsp ? word(mem_q[0]) : $urandom;
    #1;
    m_req = !c_branch && (fq.size() + out_q.size() < DEPTH);
    if (armed) begin
      check("req_valid", {31'b0, im_req_valid}, {31'b0, m_req});
      if (m_req) check("req_addr", im_req_addr, m_fetch_pc);
      check("write_enable", {31'b0, im_write_enable}, 32'd0);
    end
    acc = im_req_valid && im_req_ready && c_rst_n;
    if (rsp) void'(mem_q.pop_front());
    if (acc) begin mem_q.push_back(im_req_addr); req_cnt++; last_acc_addr = im_req_addr; end
    if (!c_rst_n) mem_q.delete();
    model_update(m_req && c_ready, rsp);
    @(posedge clock); #1;
    armed = 1'b1;
    check("if_valid", {31'b0, IF_ID_valid}, {31'b0, m_valid});
    check("if_ir", IF_ID_IR, m_ir);
    check("if_nextpc", IF_ID_nextPC, m_npc);
    if (IF_ID_valid) ir_seq.push_back(IF_ID_IR);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    c_rst_n = 1'b0; c_stall = 1'b0; c_branch = 1'b0; c_ready = 1'b0; rsp_mode = 0;
    step();
    c_rst_n = 1'b1;
    req_cnt = 0;
    ir_seq.delete();
  endtask

  initial begin
    int  vcnt;
    bit  found;
    @(posedge clock); #1;

    // Reset state
    do_reset();
    check("rst_valid", {31'b0, IF_ID_valid}, 32'd0);
    check("rst_ir", IF_ID_IR, 32'd0);
    check("rst_nextpc", IF_ID_nextPC, 32'd0);

    // Streaming with 1-cycle responses
    c_ready = 1'b1; rsp_mode = 1;
    run(10);
    for (int i = 0; i < 4; i++) check("stream_ir", ir_seq[i], 32'hA0 + 32'(i));

    // Responses withheld: credit limit of DEPTH requests
    do_reset();
    c_ready = 1'b1; rsp_mode = 0;
    run(6);
    check("credit_req_cnt", 32'(req_cnt), 32'd4);
    check("credit_blocked", {31'b0, im_req_valid}, 32'd0);
    rsp_mode = 1;
    run(6);

    // Stall while the queue fills, then drain without bubbles
    do_reset();
    c_stall = 1'b1; c_ready = 1'b1; rsp_mode = 1;
    run(6);
    check("stall_full_blocked", {31'b0, im_req_valid}, 32'd0);
    check("stall_hold_valid", {31'b0, IF_ID_valid}, 32'd0);
    c_stall = 1'b0; c_ready = 1'b0; vcnt = 0;
    for (int i = 0; i < 4; i++) begin step(); if (IF_ID_valid) vcnt++; end
    check("stall_drain_cnt", 32'(vcnt), 32'd4);

    // Branch with three requests in flight
    do_reset();
    c_ready = 1'b1; rsp_mode = 0;
    run(3);
    c_branch = 1'b1; c_bpc = 32'h40;
    step();
    c_branch = 1'b0;
    check("branch_bubble", {31'b0, IF_ID_valid}, 32'd0);
    rsp_mode = 1; found = 1'b0;
    for (int i = 0; i < 20; i++) if (!found) begin
      step();
      if (IF_ID_valid) found = 1'b1;
    end
    check("branch_target_seen", {31'b0, found}, 32'd1);
    check("branch_target_ir", IF_ID_IR, 32'hE0);
    check("branch_target_npc", IF_ID_nextPC, 32'h41);

    // Branch + stall + same-cycle response
    do_reset();
    c_ready = 1'b1; rsp_mode = 0;
    run(3);
    c_stall = 1'b1; c_branch = 1'b1; c_bpc = 32'h80; rsp_mode = 1;
    step();
    c_stall = 1'b0; c_branch = 1'b0;
    check("brstall_bubble", {31'b0, IF_ID_valid}, 32'd0);
    run(12);

    // PC wrap-around
    c_branch = 1'b1; c_bpc = 32'hFFFF_FFFE;
    step();
    c_branch = 1'b0;
    run(10);

    // Reset mid-stream with two in flight
    do_reset();
    c_ready = 1'b1; rsp_mode = 0;
    run(2);
    c_ready = 1'b0;
    c_rst_n = 1'b0;
    step();
    check("midrst_valid", {31'b0, IF_ID_valid}, 32'd0);
    check("midrst_ir", IF_ID_IR, 32'd0);
    check("midrst_nextpc", IF_ID_nextPC, 32'd0);
    c_rst_n = 1'b1; c_ready = 1'b1; rsp_mode = 1;
    step();
    check("midrst_first_addr", last_acc_addr, 32'd0);
    run(5);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      c_rst_n  = ($urandom_range(0, 199) != 0);
      c_stall  = ($urandom_range(0, 3) == 0);
      c_branch = ($urandom_range(0, 19) == 0);
      c_bpc    = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 4095));
      c_ready  = ($urandom_range(0, 9) < 7);
      rsp_mode = 2;
      step();
    end
    c_rst_n = 1'b1; c_stall = 1'b0; c_branch = 1'b0; c_ready = 1'b0; rsp_mode = 1;
    run(12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
